// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH valid/data stages joined by a
// valid/ready handshake. Invalid stages always accept, so bubbles are
// squeezed out while the consumer stalls. A flush clears every valid bit,
// and count reports how many stages hold a beat.
module pipe_stage_chain #(
  parameter int              DW        = 32,
  parameter int              DEPTH     = 2,
  parameter logic [DW-1:0]   RST_VALUE = '0,
  parameter int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DW-1:0]    d_d [DEPTH];
  logic [DEPTH:0]   rdy;

  // Ready ripples back from the consumer; any empty stage makes everything
  // upstream of it ready.
  always_comb begin
    rdy = '0;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  // Next state: each ready stage takes its upstream neighbour; data only
  // moves on a valid beat so an empty stage keeps its last payload.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = in_valid;
      if (in_valid) d_d[0] = in_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) d_d[k] = d_q[k-1];
      end
    end
    if (flush) v_d = '0;
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= RST_VALUE;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // Occupancy is a plain popcount of the valid bits.
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CNT_W'(v_q[k]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed and randomized checks of pipe_stage_chain at DEPTH=2 (main
// instance) and DEPTH=3 (bubble-collapse instance).
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rstn;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int n_tot = 0;
  int n_bad = 0;

  logic [31:0] sb_q[$];
  logic        exp_rdy;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DW(32), .DEPTH(2)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_stage_chain #(.DW(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are changed after this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 32'hA5A5A5A5; b_out_ready = 1'b0;

    // reset with a beat on the input
    tick(); tick();
    rstn = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count",     count,     0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_data",  out_data,  0);
    chk("rst3_count",    b_count,   0);

    // streaming 1,2,3
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
    tick(); in_data = 32'h2; #1;
    chk("str_lat_valid", out_valid, 0);
    chk("str_lat_count", count, 1);
    tick(); in_data = 32'h3; #1;
    chk("str_d1_valid", out_valid, 1);
    chk("str_d1", out_data, 32'h1);
    chk("str_cnt1", count, 2);
    chk("str_rdy", in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    chk("str_d2", out_data, 32'h2);
    chk("str_cnt2", count, 2);
    tick(); #1;
    chk("str_d3", out_data, 32'h3);
    chk("str_cnt3", count, 1);
    tick(); #1;
    chk("str_empty_valid", out_valid, 0);
    chk("str_empty_cnt", count, 0);
    chk("str_empty_data", out_data, 32'h3);

    // back-pressure 10,20,30
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h10; #1;
    chk("bp_rdy0", in_ready, 1);
    tick(); in_data = 32'h20; #1;
    chk("bp_rdy1", in_ready, 1);
    tick(); in_data = 32'h30; #1;
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_full_cnt", count, 2);
    chk("bp_full_data", out_data, 32'h10);
    tick(); #1;
    chk("bp_stall_cnt", count, 2);
    chk("bp_stall_data", out_data, 32'h10);
    out_ready = 1'b1; #1;
    chk("bp_comb_rdy", in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    chk("bp_d20", out_data, 32'h20);
    chk("bp_cnt_keep", count, 2);
    tick(); #1;
    chk("bp_d30", out_data, 32'h30);
    chk("bp_cnt1", count, 1);
    tick(); #1;
    chk("bp_empty", count, 0);

    // bubble collapse on the DEPTH=3 chain
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h7;
    tick(); b_in_valid = 1'b0;
    tick(); b_in_valid = 1'b1; b_in_data = 32'h8;
    tick(); b_in_valid = 1'b0;
    tick(); #1;
    chk("bub_cnt", b_count, 2);
    chk("bub_valid", b_out_valid, 1);
    chk("bub_data", b_out_data, 32'h7);
    chk("bub_rdy", b_in_ready, 1);
    b_out_ready = 1'b1;
    tick(); #1;
    chk("bub_next", b_out_data, 32'h8);
    chk("bub_cnt1", b_count, 1);
    tick(); #1;
    chk("bub_empty", b_count, 0);

    // flush while holding 4,5 with a beat presented
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h4;
    tick(); in_data = 32'h5;
    tick(); flush = 1'b1; in_data = 32'h6; #1;
    chk("fl_pre_cnt", count, 2);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("fl_cnt", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_data_kept", out_data, 32'h4);
    out_ready = 1'b1;
    tick(); tick(); #1;
    chk("fl_no_ghost", out_valid, 0);

    // synchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h9;
    tick(); tick(); in_valid = 1'b0; flush = 1'b0; rstn = 1'b0;
    tick(); rstn = 1'b1; #1;
    chk("mrst_cnt", count, 0);
    chk("mrst_data", out_data, 0);
    out_ready = 1'b1;
    tick(); #1;
    chk("mrst_no_beat", out_valid, 0);

    // random traffic against a FIFO scoreboard
    sb_q.delete();
    for (int i = 0; i < 10000; i++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      #1;
      exp_rdy = (sb_q.size() < 2) || out_ready;
      chk("rnd_in_ready", in_ready, exp_rdy);
      chk("rnd_count", count, sb_q.size());
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("rnd_underflow", out_valid, 1'b0);
        else chk("rnd_data", out_data, sb_q.pop_front());
      end
      if (flush) sb_q.delete();
      else if (in_valid && exp_rdy) sb_q.push_back(in_data);
    end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    chk("rnd_final_cnt", count, sb_q.size());

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
